// File: rtl/rx_cmd_sequencer.sv
// rx_cmd_sequencer: assembles SYNC/CMD/ARG_H/ARG_L/CHK frames from the
// UART byte stream and hands good commands to the consumer via valid/ack.
module rx_cmd_sequencer #(
  parameter logic [7:0] SYNC_BYTE      = 8'hAA,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         TIMEOUT_W      = 20
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  input  logic        CmdAck,
  input  logic        ClearErrors,
  output logic        CmdValid,
  output logic [7:0]  CmdCode,
  output logic [15:0] CmdArg,
  output logic        Busy,
  output logic [7:0]  ChkErrCount,
  output logic [7:0]  TimeoutCount,
  output logic [7:0]  DropCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ARGH,
    S_ARGL,
    S_CHK,
    S_HOLD
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TMO_LAST =
    TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t               r_state;
  state_t               w_next;
  logic [TIMEOUT_W-1:0] r_tmo;
  logic [7:0]           r_cmd;
  logic [7:0]           r_argh;
  logic [7:0]           r_argl;
  logic                 r_valid;
  logic [7:0]           r_code;
  logic [15:0]          r_arg;
  logic [7:0]           r_chk_cnt;
  logic [7:0]           r_tmo_cnt;
  logic [7:0]           r_drop_cnt;

  logic                 w_in_frame;
  logic                 w_tmo_hit;
  logic                 w_tmo_evt;
  logic                 w_chk_err;
  logic                 w_drop;
  logic                 w_load;
  logic [7:0]           w_sum;

  assign w_sum     = r_cmd ^ r_argh ^ r_argl;
  assign w_tmo_hit = w_in_frame && (r_tmo == TMO_LAST) && !RxValid;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v,
    input logic       e
  );
    return (e && v != 8'hFF) ? v + 8'd1 : v;
  endfunction

  // next-state decode plus one-cycle event flags
  always_comb begin
    w_next     = r_state;
    w_in_frame = 1'b0;
    w_tmo_evt  = 1'b0;
    w_chk_err  = 1'b0;
    w_drop     = 1'b0;
    w_load     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (RxValid && RxData == SYNC_BYTE)
          w_next = S_CMD;
      end
      S_CMD, S_ARGH, S_ARGL: begin
        w_in_frame = 1'b1;
        if (RxValid) begin
          unique case (r_state)
            S_CMD:   w_next = S_ARGH;
            S_ARGH:  w_next = S_ARGL;
            default: w_next = S_CHK;
          endcase
        end else if (r_tmo == TMO_LAST) begin
          w_next    = S_IDLE;
          w_tmo_evt = 1'b1;
        end
      end
      S_CHK: begin
        w_in_frame = 1'b1;
        if (RxValid) begin
          if (RxData == w_sum) begin
            w_load = 1'b1;
            w_next = S_HOLD;
          end else begin
            w_chk_err = 1'b1;
            w_next    = S_IDLE;
          end
        end else if (r_tmo == TMO_LAST) begin
          w_next    = S_IDLE;
          w_tmo_evt = 1'b1;
        end
      end
      S_HOLD: begin
        w_drop = RxValid;
        if (CmdAck)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // inter-byte timer, idle-counting only while inside a frame
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)
      r_tmo <= '0;
    else if (w_in_frame && !RxValid && !w_tmo_hit)
      r_tmo <= r_tmo + TIMEOUT_W'(1);
    else
      r_tmo <= '0;
  end

  // shadow registers for the frame being assembled
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cmd  <= '0;
      r_argh <= '0;
      r_argl <= '0;
    end else if (RxValid) begin
      if (r_state == S_CMD)  r_cmd  <= RxData;
      if (r_state == S_ARGH) r_argh <= RxData;
      if (r_state == S_ARGL) r_argl <= RxData;
    end
  end

  // presented command; code/arg persist until the next good frame
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_valid <= 1'b0;
      r_code  <= '0;
      r_arg   <= '0;
    end else begin
      r_valid <= (w_next == S_HOLD);
      if (w_load) begin
        r_code <= r_cmd;
        r_arg  <= {r_argh, r_argl};
      end
    end
  end

  // saturating diagnostics counters, clear beats increment
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_chk_cnt  <= '0;
      r_tmo_cnt  <= '0;
      r_drop_cnt <= '0;
    end else if (ClearErrors) begin
      r_chk_cnt  <= '0;
      r_tmo_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_chk_cnt  <= sat_inc(r_chk_cnt, w_chk_err);
      r_tmo_cnt  <= sat_inc(r_tmo_cnt, w_tmo_evt);
      r_drop_cnt <= sat_inc(r_drop_cnt, w_drop);
    end
  end

  assign CmdValid     = r_valid;
  assign CmdCode      = r_code;
  assign CmdArg       = r_arg;
  assign Busy         = (r_state != S_IDLE);
  assign ChkErrCount  = r_chk_cnt;
  assign TimeoutCount = r_tmo_cnt;
  assign DropCount    = r_drop_cnt;

endmodule

// File: tb/tb_rx_cmd_sequencer.sv
// tb_rx_cmd_sequencer: directed frames against hand-computed results
// for rx_cmd_sequencer (short timeout build).
module tb_rx_cmd_sequencer;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [7:0]  RxData;
  logic        RxValid;
  logic        CmdAck;
  logic        ClearErrors;
  logic        CmdValid;
  logic [7:0]  CmdCode;
  logic [15:0] CmdArg;
  logic        Busy;
  logic [7:0]  ChkErrCount;
  logic [7:0]  TimeoutCount;
  logic [7:0]  DropCount;

  int n_checks = 0;
  int n_errors = 0;

  rx_cmd_sequencer #(
    .SYNC_BYTE      (8'hAA),
    .TIMEOUT_CYCLES (16),
    .TIMEOUT_W      (5)
  ) u_dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .RxData       (RxData),
    .RxValid      (RxValid),
    .CmdAck       (CmdAck),
    .ClearErrors  (ClearErrors),
    .CmdValid     (CmdValid),
    .CmdCode      (CmdCode),
    .CmdArg       (CmdArg),
    .Busy         (Busy),
    .ChkErrCount  (ChkErrCount),
    .TimeoutCount (TimeoutCount),
    .DropCount    (DropCount)
  );

  always #5 Clock = ~Clock;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the sampling edge
  task automatic send(input logic [7:0] b);
    RxData  = b;
    RxValid = 1'b1;
    @(negedge Clock);
    RxValid = 1'b0;
    RxData  = 8'h00;
  endtask

  task automatic frame(
    input logic [7:0] c,
    input logic [7:0] h,
    input logic [7:0] l,
    input logic [7:0] k
  );
    send(8'hAA);
    send(c);
    send(h);
    send(l);
    send(k);
  endtask

  task automatic ack();
    CmdAck = 1'b1;
    @(negedge Clock);
    CmdAck = 1'b0;
  endtask

  initial begin
    Reset_n     = 1'b0;
    RxData      = 8'h00;
    RxValid     = 1'b0;
    CmdAck      = 1'b0;
    ClearErrors = 1'b0;
    #3;
    check("rst_valid", 32'(CmdValid), 32'h0);
    check("rst_code", 32'(CmdCode), 32'h0);
    check("rst_arg", 32'(CmdArg), 32'h0);
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst_cnts",
          {8'h0, ChkErrCount, TimeoutCount, DropCount}, 32'h0);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);

    // good frame, ack handshake
    send(8'hAA);
    send(8'h12);
    send(8'h34);
    send(8'h56);
    check("pre_chk_valid", 32'(CmdValid), 32'h0);
    send(8'h70);
    check("good_valid", 32'(CmdValid), 32'h1);
    check("good_code", 32'(CmdCode), 32'h12);
    check("good_arg", 32'(CmdArg), 32'h3456);
    check("good_busy", 32'(Busy), 32'h1);
    ack();
    check("ack_valid", 32'(CmdValid), 32'h0);
    check("ack_busy", 32'(Busy), 32'h0);
    check("ack_code_kept", 32'(CmdCode), 32'h12);
    ack();
    check("stray_ack", 32'(CmdValid), 32'h0);

    // bad checksum then good frame
    frame(8'h12, 8'h34, 8'h56, 8'h71);
    check("bad_valid", 32'(CmdValid), 32'h0);
    check("bad_busy", 32'(Busy), 32'h0);
    check("bad_cnt", 32'(ChkErrCount), 32'h1);
    frame(8'h01, 8'h00, 8'h02, 8'h03);
    check("g2_valid", 32'(CmdValid), 32'h1);
    check("g2_code", 32'(CmdCode), 32'h01);
    check("g2_arg", 32'(CmdArg), 32'h0002);
    ack();

    // sync inside a frame is data
    frame(8'hAA, 8'hAA, 8'h01, 8'h01);
    check("sync_data_code", 32'(CmdCode), 32'hAA);
    check("sync_data_arg", 32'(CmdArg), 32'hAA01);
    ack();

    // timeout: 16 idle cycles after the 05 strobe
    send(8'hAA);
    send(8'h05);
    repeat (15) @(negedge Clock);
    check("tmo_busy15", 32'(Busy), 32'h1);
    @(negedge Clock);
    check("tmo_busy16", 32'(Busy), 32'h0);
    check("tmo_cnt", 32'(TimeoutCount), 32'h1);

    // byte on the boundary cycle wins
    send(8'hAA);
    send(8'h05);
    repeat (15) @(negedge Clock);
    send(8'h34);
    check("tmo_edge_busy", 32'(Busy), 32'h1);
    send(8'h56);
    send(8'h67);
    check("tmo_edge_valid", 32'(CmdValid), 32'h1);
    check("tmo_edge_code", 32'(CmdCode), 32'h05);
    check("tmo_edge_arg", 32'(CmdArg), 32'h3456);
    check("tmo_edge_cnt", 32'(TimeoutCount), 32'h1);
    ack();

    // drops while holding
    frame(8'h12, 8'h34, 8'h56, 8'h70);
    send(8'hAA);
    send(8'h11);
    send(8'h22);
    check("drop_cnt", 32'(DropCount), 32'h3);
    check("drop_valid", 32'(CmdValid), 32'h1);
    check("drop_code", 32'(CmdCode), 32'h12);
    check("drop_arg", 32'(CmdArg), 32'h3456);
    CmdAck  = 1'b1;
    RxData  = 8'hAA;
    RxValid = 1'b1;
    @(negedge Clock);
    CmdAck  = 1'b0;
    RxValid = 1'b0;
    check("drop_ack_cnt", 32'(DropCount), 32'h4);
    check("drop_ack_busy", 32'(Busy), 32'h0);
    frame(8'h05, 8'h00, 8'h01, 8'h04);
    check("post_drop_code", 32'(CmdCode), 32'h05);
    check("post_drop_arg", 32'(CmdArg), 32'h0001);
    ack();

    // saturation
    for (int i = 0; i < 260; i++)
      frame(8'h00, 8'h00, 8'h00, 8'h01);
    check("sat_cnt", 32'(ChkErrCount), 32'hFF);

    // clear wins over a concurrent error
    send(8'hAA);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    ClearErrors = 1'b1;
    send(8'h01);
    ClearErrors = 1'b0;
    check("clr_chk", 32'(ChkErrCount), 32'h0);
    check("clr_tmo", 32'(TimeoutCount), 32'h0);
    check("clr_drop", 32'(DropCount), 32'h0);

    // async reset in GET_ARGL
    send(8'hAA);
    send(8'h12);
    send(8'h34);
    check("argl_busy", 32'(Busy), 32'h1);
    #2 Reset_n = 1'b0;
    #1;
    check("ar1_busy", 32'(Busy), 32'h0);
    check("ar1_code", 32'(CmdCode), 32'h0);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    send(8'h34);
    send(8'h56);
    check("ar1_garb_busy", 32'(Busy), 32'h0);
    check("ar1_garb_valid", 32'(CmdValid), 32'h0);

    // async reset in HOLD
    frame(8'h12, 8'h34, 8'h56, 8'h70);
    send(8'h11);
    check("hold_valid", 32'(CmdValid), 32'h1);
    #3 Reset_n = 1'b0;
    #1;
    check("ar2_valid", 32'(CmdValid), 32'h0);
    check("ar2_code", 32'(CmdCode), 32'h0);
    check("ar2_arg", 32'(CmdArg), 32'h0);
    check("ar2_busy", 32'(Busy), 32'h0);
    check("ar2_drop", 32'(DropCount), 32'h0);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    send(8'h34);
    send(8'h56);
    check("ar2_garb_busy", 32'(Busy), 32'h0);
    check("ar2_garb_valid", 32'(CmdValid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
